bulb_health_monitor: RTL

Upstream stage of the chandelier brightness controller. Produces its 4-bit bulb_status vector (1 = working) from raw per-bulb current-sense inputs. Each bulb is sampled only while driven, and the result is debounced with consecutive-sample counters. Fault events and a saturating fault count are reported for diagnostics.

---
 rtl/chandelier_pkg.sv | 28 ++
 rtl/bulb_channel.sv | 122 ++++++++++++
 rtl/bulb_health_monitor.sv | 82 ++++++++
 3 files changed

// File: rtl/chandelier_pkg.sv
// chandelier_pkg: definitions shared by the chandelier bulb-health and brightness stages.
//
// Contents:
//   NUM_BULBS          number of bulb channels. The downstream brightness stage assumes 4.
//   DEFAULT_*_SAMPLES  default debounce thresholds for the health monitor.
//   bulb_state_t       per-channel health state.
//   debounce_cnt_w()   width of a debounce counter able to hold either threshold.
package chandelier_pkg;

  localparam int NUM_BULBS               = 4;
  localparam int DEFAULT_FAIL_SAMPLES    = 3;
  localparam int DEFAULT_RECOVER_SAMPLES = 8;

  typedef enum logic [1:0] {
    OK         = 2'd0,
    SUSPECT    = 2'd1,
    FAULT      = 2'd2,
    RECOVERING = 2'd3
  } bulb_state_t;

  // Width of a counter that holds 0..max(fail_samples, recover_samples).
  function automatic int debounce_cnt_w(input int fail_samples, input int recover_samples);
    int m;
    m = (fail_samples > recover_samples) ? fail_samples : recover_samples;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bulb_channel.sv
// bulb_channel: health FSM and debounce counter for one bulb.
//
// Build option: define FAULT_LATCH_EN to make FAULT sticky. Good samples then do not
// leave FAULT, and only clear or rst restores the bulb. If the macro is undefined, a
// bulb recovers after RECOVER_SAMPLES consecutive good samples.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset; returns the channel to OK
//   clear          synchronous clear to OK; wins over a coincident sample
//   valid          this cycle carries a sample (sample_en & drive_on[i])
//   good           sample value; 1 = current detected
//   status         registered; 0 while in FAULT or RECOVERING
//   entered_fault  combinational strobe, high in the cycle whose sample moves the
//                  channel from OK or SUSPECT into FAULT. The top level registers it.
module bulb_channel
  import chandelier_pkg::*;
#(
  parameter int FAIL_SAMPLES    = DEFAULT_FAIL_SAMPLES,
  parameter int RECOVER_SAMPLES = DEFAULT_RECOVER_SAMPLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic valid,
  input  logic good,
  output logic status,
  output logic entered_fault
);

  localparam int            CW       = debounce_cnt_w(FAIL_SAMPLES, RECOVER_SAMPLES);
  localparam logic [CW-1:0] FAIL_LIM = CW'(FAIL_SAMPLES);
  localparam logic [CW-1:0] REC_LIM  = CW'(RECOVER_SAMPLES);

  bulb_state_t   state_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt_reg + CW'(1);

  // The top level uses this strobe for both fault_event and fault_count. A return
  // from RECOVERING to FAULT is deliberately excluded, because it is not a new fault.
  always_comb begin
    entered_fault = 1'b0;
    if (!rst && !clear && valid && !good) begin
      if (state_reg == OK && FAIL_SAMPLES == 1)
        entered_fault = 1'b1;
      if (state_reg == SUSPECT && cnt_inc == FAIL_LIM)
        entered_fault = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_reg <= OK;
      cnt_reg   <= '0;
      status    <= 1'b1;
    end else if (valid) begin
      case (state_reg)
        OK: begin
          if (!good) begin
            if (FAIL_SAMPLES == 1) begin
              state_reg <= FAULT;
              cnt_reg   <= '0;
              status    <= 1'b0;
            end else begin
              state_reg <= SUSPECT;
              cnt_reg   <= CW'(1);
            end
          end
        end
        SUSPECT: begin
          if (good) begin
            state_reg <= OK;
            cnt_reg   <= '0;
          end else if (cnt_inc == FAIL_LIM) begin
            state_reg <= FAULT;
            cnt_reg   <= '0;
            status    <= 1'b0;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        FAULT: begin
`ifdef FAULT_LATCH_EN
          // Sticky fault: hold until clear or rst.
          state_reg <= FAULT;
`else
          if (good) begin
            if (RECOVER_SAMPLES == 1) begin
              state_reg <= OK;
              cnt_reg   <= '0;
              status    <= 1'b1;
            end else begin
              state_reg <= RECOVERING;
              cnt_reg   <= CW'(1);
            end
          end
`endif
        end
        RECOVERING: begin
          if (!good) begin
            state_reg <= FAULT;
            cnt_reg   <= '0;
          end else if (cnt_inc == REC_LIM) begin
            state_reg <= OK;
            cnt_reg   <= '0;
            status    <= 1'b1;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        default: begin
          state_reg <= OK;
          cnt_reg   <= '0;
          status    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/bulb_health_monitor.sv
// bulb_health_monitor: debounced per-bulb health status for the chandelier brightness
// controller.
//
// Build option: define FAULT_LATCH_EN to make faults sticky until clear_faults or rst.
// The ports are the same in both builds.
//
// Ports:
//   clk           system clock; all logic runs on the rising edge
//   rst           synchronous, active-high reset; has priority over clear_faults
//   sample_en     sample strobe
//   drive_on      per-bulb drive command; a bulb is sampled only while driven
//   sense         per-bulb current detect; 1 = current flows
//   clear_faults  single-cycle pulse; returns every channel to OK and zeroes the count
//   bulb_status   registered; 1 = bulb considered working
//   fault_event   registered one-cycle pulse; one or more bulbs entered FAULT
//   fault_count   registered saturating count of entries into FAULT
//
// NUM_BULBS must remain 4, because the brightness stage consumes a 4-bit status vector.
module bulb_health_monitor
  import chandelier_pkg::*;
#(
  parameter int NUM_BULBS       = chandelier_pkg::NUM_BULBS,
  parameter int FAIL_SAMPLES    = chandelier_pkg::DEFAULT_FAIL_SAMPLES,
  parameter int RECOVER_SAMPLES = chandelier_pkg::DEFAULT_RECOVER_SAMPLES,
  parameter int CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en,
  input  logic [NUM_BULBS-1:0] drive_on,
  input  logic [NUM_BULBS-1:0] sense,
  input  logic                 clear_faults,
  output logic [NUM_BULBS-1:0] bulb_status,
  output logic                 fault_event,
  output logic [CNT_W-1:0]     fault_count
);

  localparam int               PW      = $clog2(NUM_BULBS + 1);
  localparam int               SW      = CNT_W + PW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_BULBS-1:0] entered;
  logic [PW-1:0]        enter_cnt;
  logic [SW-1:0]        sum_wide;
  logic [CNT_W-1:0]     count_next;

  for (genvar gi = 0; gi < NUM_BULBS; gi++) begin : g_chan
    bulb_channel #(
      .FAIL_SAMPLES    (FAIL_SAMPLES),
      .RECOVER_SAMPLES (RECOVER_SAMPLES)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .clear         (clear_faults),
      .valid         (sample_en & drive_on[gi]),
      .good          (sense[gi]),
      .status        (bulb_status[gi]),
      .entered_fault (entered[gi])
    );
  end

  // Several bulbs can enter FAULT in the same cycle. Each one adds to the count, and the
  // sum is formed in a wider word so that the saturation test can see any overflow.
  always_comb begin
    enter_cnt = '0;
    for (int i = 0; i < NUM_BULBS; i++)
      enter_cnt = enter_cnt + PW'(entered[i]);
    sum_wide   = SW'(fault_count) + SW'(enter_cnt);
    count_next = (sum_wide > SW'(CNT_MAX)) ? CNT_MAX : sum_wide[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clear_faults) begin
      fault_event <= 1'b0;
      fault_count <= '0;
    end else begin
      fault_event <= |entered;
      fault_count <= count_next;
    end
  end

endmodule
